// File: rtl/button_conditioner.sv
// Pushbutton front end: synchronises and debounces four raw buttons, then presents one
// accepted one-hot press per press-and-release, held long enough for the slow game tick.
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned HOLD_CYCLES     = 25_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn_raw,
    output logic [3:0] btn,
    output logic       press_pulse,
    output logic       multi_err,
    output logic       busy
);

    localparam int unsigned CntW     = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned HoldW    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CntW-1:0]  CntLast  = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StHold,
        StWaitRelease
    } state_e;

    logic [3:0]       s1;
    logic [3:0]       s2;
    logic [3:0]       deb;
    logic [CntW-1:0]  cnt [4];
    state_e           state;
    logic [HoldW-1:0] hold_cnt;
    logic             deb_none;
    logic             deb_one_hot;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= btn_raw;
            s2 <= s1;
        end
    end

    // A sample that agrees with the current level restarts the count, so only an
    // unbroken run of DEBOUNCE_CYCLES disagreeing samples moves the level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            deb <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (s2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CntLast) begin
                    deb[i] <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CntW'(1);
                end
            end
        end
    end

    assign deb_none    = (deb == 4'b0000);
    assign deb_one_hot = !deb_none && ((deb & (deb - 4'd1)) == 4'b0000);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= StIdle;
            btn         <= '0;
            press_pulse <= 1'b0;
            multi_err   <= 1'b0;
            hold_cnt    <= '0;
        end else begin
            press_pulse <= 1'b0;
            multi_err   <= 1'b0;
            case (state)
                StIdle: begin
                    if (deb_one_hot) begin
                        btn         <= deb;
                        press_pulse <= 1'b1;
                        hold_cnt    <= '0;
                        state       <= StHold;
                    end else if (!deb_none) begin
                        multi_err <= 1'b1;
                        state     <= StWaitRelease;
                    end
                end
                // The hold runs to completion regardless of what the buttons do meanwhile.
                StHold: begin
                    if (hold_cnt == HoldLast) begin
                        btn   <= '0;
                        state <= StWaitRelease;
                    end else begin
                        hold_cnt <= hold_cnt + HoldW'(1);
                    end
                end
                StWaitRelease: begin
                    if (deb_none) begin
                        state <= StIdle;
                    end
                end
                default: begin
                    btn   <= '0;
                    state <= StIdle;
                end
            endcase
        end
    end

    assign busy = (state != StIdle);

endmodule

// File: tb/tb_button_conditioner.sv
// Directed and randomised bench for button_conditioner, checked against a
// sample-history reference model of the debounce and press-acceptance rules.
module tb_button_conditioner;

    localparam int D = 4;
    localparam int H = 8;

    logic       clk;
    logic       reset;
    logic [3:0] btn_raw;
    logic [3:0] btn;
    logic       press_pulse;
    logic       multi_err;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int n_pulse = 0;
    int n_merr = 0;
    int n_btn = 0;

    button_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .HOLD_CYCLES    (H)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_raw    (btn_raw),
        .btn        (btn),
        .press_pulse(press_pulse),
        .multi_err  (multi_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: raw samples, synchronised-sample history, accepted-press timeline.
    logic [3:0] m_samp [$];
    logic [3:0] m_hist [$];
    logic [3:0] m_deb;
    logic [3:0] m_btn;
    logic       m_pulse;
    logic       m_merr;
    int         m_hold_left;
    bit         m_wait;

    function automatic void model_reset();
        m_samp.delete();
        m_hist.delete();
        m_deb       = 4'b0;
        m_btn       = 4'b0;
        m_pulse     = 1'b0;
        m_merr      = 1'b0;
        m_hold_left = 0;
        m_wait      = 1'b0;
    endfunction

    function automatic logic m_busy();
        return (m_hold_left > 0) || m_wait;
    endfunction

    function automatic void model_edge(input logic [3:0] raw);
        logic [3:0] s2_old;
        logic [3:0] deb_next;
        logic [3:0] h;
        bit         all_diff;
        s2_old  = (m_samp.size() >= 2) ? m_samp[m_samp.size() - 2] : 4'b0;
        m_pulse = 1'b0;
        m_merr  = 1'b0;
        if (m_hold_left > 0) begin
            m_hold_left--;
            if (m_hold_left == 0) begin
                m_btn  = 4'b0;
                m_wait = 1'b1;
            end
        end else if (m_wait) begin
            if (m_deb == 4'b0) m_wait = 1'b0;
        end else if ($countones(m_deb) == 1) begin
            m_btn       = m_deb;
            m_pulse     = 1'b1;
            m_hold_left = H;
        end else if ($countones(m_deb) >= 2) begin
            m_merr = 1'b1;
            m_wait = 1'b1;
        end
        // A level changes once the last D synchronised samples all disagree with it.
        m_hist.push_back(s2_old);
        if (m_hist.size() > D) void'(m_hist.pop_front());
        deb_next = m_deb;
        if (m_hist.size() == D) begin
            for (int i = 0; i < 4; i++) begin
                all_diff = 1'b1;
                for (int j = 0; j < D; j++) begin
                    h = m_hist[j];
                    if (h[i] == m_deb[i]) all_diff = 1'b0;
                end
                if (all_diff) deb_next[i] = ~m_deb[i];
            end
        end
        m_deb = deb_next;
        m_samp.push_back(raw);
        if (m_samp.size() > 2) void'(m_samp.pop_front());
    endfunction

    task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(btn_raw);
        #1;
        check4("btn", btn, m_btn);
        check1("press_pulse", press_pulse, m_pulse);
        check1("multi_err", multi_err, m_merr);
        check1("busy", busy, m_busy());
        check1("btn_onehot0", $onehot0(btn), 1'b1);
        check1("strobes_exclusive", press_pulse & multi_err, 1'b0);
        if (press_pulse) n_pulse++;
        if (multi_err) n_merr++;
        if (btn != 4'b0) n_btn++;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic clear_counts();
        n_pulse = 0;
        n_merr  = 0;
        n_btn   = 0;
    endtask

    task automatic release_and_idle(input string tag, output int edges);
        btn_raw = 4'b0;
        edges   = 0;
        while (busy !== 1'b0 && edges < 60) begin
            tick();
            edges++;
        end
        check1({tag, " idle"}, busy, 1'b0);
    endtask

    initial begin
        int edges;
        int dur;
        int r;
        logic [3:0] pat;

        reset   = 1'b0;
        btn_raw = 4'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        check4("reset btn", btn, 4'b0);
        check1("reset press_pulse", press_pulse, 1'b0);
        check1("reset multi_err", multi_err, 1'b0);
        check1("reset busy", busy, 1'b0);
        reset = 1'b1;

        // Clean press
        clear_counts();
        btn_raw = 4'b0001;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == 6) check4("clean btn@6", btn, 4'b0000);
            if (k == 7) begin
                check4("clean btn@7", btn, 4'b0001);
                check1("clean pulse@7", press_pulse, 1'b1);
            end
        end
        check_int("clean hold cycles", n_btn, H);
        check_int("clean pulses", n_pulse, 1);
        release_and_idle("clean", edges);
        check_int("clean release latency", edges, D + 3);

        // Bounce on bit 2
        clear_counts();
        for (int k = 1; k <= 10; k++) begin
            btn_raw = (k % 2 == 1) ? 4'b0100 : 4'b0000;
            tick();
        end
        check_int("bounce quiet pulses", n_pulse, 0);
        btn_raw = 4'b0100;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 6) check4("bounce btn@6", btn, 4'b0000);
            if (k == 7) check4("bounce btn@7", btn, 4'b0100);
        end
        check_int("bounce pulses", n_pulse, 1);
        release_and_idle("bounce", edges);

        // Simultaneous multi-press, then a single press
        clear_counts();
        btn_raw = 4'b0110;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (k == 7) begin
                check1("multi err@7", multi_err, 1'b1);
                check4("multi btn@7", btn, 4'b0000);
            end
        end
        check_int("multi errs", n_merr, 1);
        check_int("multi pulses", n_pulse, 0);
        release_and_idle("multi", edges);
        btn_raw = 4'b1000;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (k == 7) check4("after multi btn@7", btn, 4'b1000);
        end
        release_and_idle("after multi", edges);

        // Long hold, then a second press
        clear_counts();
        btn_raw = 4'b0010;
        run(100);
        check_int("held pulses", n_pulse, 1);
        release_and_idle("held", edges);
        btn_raw = 4'b0010;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (k == 7) check4("second press btn@7", btn, 4'b0010);
        end
        check_int("held total pulses", n_pulse, 2);
        release_and_idle("second press", edges);

        // Early release still gets the full hold
        clear_counts();
        btn_raw = 4'b0001;
        run(12);
        btn_raw = 4'b0000;
        run(18);
        check_int("early release hold cycles", n_btn, H);
        release_and_idle("early release", edges);

        // Staggered press: first accepted, second ignored
        clear_counts();
        btn_raw = 4'b0001;
        tick();
        btn_raw = 4'b0011;
        for (int k = 2; k <= 20; k++) begin
            tick();
            if (k == 7) check4("stagger btn@7", btn, 4'b0001);
        end
        check_int("stagger errs", n_merr, 0);
        check_int("stagger pulses", n_pulse, 1);
        release_and_idle("stagger", edges);

        // Reset mid-hold, button still down at release
        btn_raw = 4'b0100;
        run(9);
        check4("pre-reset btn", btn, 4'b0100);
        #2;
        reset = 1'b0;
        #1;
        check4("async reset btn", btn, 4'b0000);
        check1("async reset busy", busy, 1'b0);
        check1("async reset pulse", press_pulse, 1'b0);
        check1("async reset merr", multi_err, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        model_reset();
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 7) check4("post-reset btn@7", btn, 4'b0100);
        end
        release_and_idle("post-reset", edges);

        // Randomised segments against the model
        for (int s = 0; s < 60; s++) begin
            r = $urandom_range(0, 9);
            dur = $urandom_range(1, 25);
            if (r <= 3) begin
                pat = 4'b0000;
            end else if (r <= 7) begin
                pat = 4'b0001 << $urandom_range(0, 3);
            end else begin
                pat = 4'($urandom_range(0, 15));
                if (r == 9) dur = 1;
            end
            btn_raw = pat;
            run(dur);
        end
        release_and_idle("random", edges);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Front-end conditioning stage between the four raw board pushbuttons and the Simon game top level. Synchronises each raw button into the 100 MHz domain, debounces it, and accepts one press per press-and-release. Each accepted press is presented on `btn` as a one-hot code, held long enough for the slow game tick to sample it. Multi-button presses are rejected and flagged.

## Interface
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive stable synchronised cycles required to change a debounced level (10 ms at 100 MHz); must be ≥2.
- `HOLD_CYCLES`, 25_000_000: clk cycles an accepted press is held on `btn` (250 ms); must be ≥1.
- `clk`  in  1  100 MHz system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `btn_raw`  in  4  raw, bouncing, asynchronous pushbuttons; 1 = pressed.
- `btn`  out  4  accepted press, one-hot (bit i = button i); 0 when none; feeds the game's `btn` input.
- `press_pulse`  out  1  single-cycle strobe on the first cycle `btn` becomes non-zero.
- `multi_err`  out  1  single-cycle strobe when a press is rejected for having >1 button down.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- Synchroniser: two flops per bit (`s1`, `s2`), reset to 0.
- Debouncer per bit: debounced level `deb[i]` (reset 0), counter `cnt[i]` of width $clog2(DEBOUNCE_CYCLES), reset 0.
  - `s2[i] == deb[i]`: `cnt[i]` <= 0.
  - `s2[i] != deb[i]` and `cnt[i] < DEBOUNCE_CYCLES-1`: `cnt[i]` increments.
  - `s2[i] != deb[i]` and `cnt[i] == DEBOUNCE_CYCLES-1`: `deb[i]` <= `s2[i]`, `cnt[i]` <= 0.
  - A single-cycle glitch that agrees with `deb` restarts the count. Counters never wrap.
- FSM states: IDLE, HOLD, WAIT_RELEASE. Reset state is IDLE.
  - IDLE, `deb == 0`: stay.
  - IDLE, `deb` one-hot: `btn` <= `deb`, `press_pulse` <= 1, hold counter <= 0, go to HOLD.
  - IDLE, `deb` has ≥2 bits set: `multi_err` <= 1, `btn` stays 0, go to WAIT_RELEASE.
  - HOLD: hold counter increments each cycle. When it reaches HOLD_CYCLES-1: `btn` <= 0, go to WAIT_RELEASE.
  - HOLD ignores changes on `deb`: releasing early does not shorten the hold, and extra buttons do not alter `btn` or raise `multi_err`.
  - WAIT_RELEASE: go to IDLE on the first cycle `deb == 0`, otherwise stay. No press is accepted until IDLE is re-entered.
- `btn` is only ever 0 or one-hot.
- `press_pulse` and `multi_err` are never high in the same cycle, and each is high for exactly 1 cycle per event.

## Timing
- Reset values: `btn` = 0, `press_pulse` = 0, `multi_err` = 0, `busy` = 0. All sync flops, `deb`, all counters and the FSM are cleared.
- `reset` is asynchronous assert, clean release. Asserting it mid-HOLD clears `btn` immediately, with no wait for a clock.
- A button already held at reset release is seen as a fresh press once debounced.
- Press latency: raw goes high and stays stable, first sampled at edge 1.
  - `s2` is high after edge 2; `deb` is high after edge DEBOUNCE_CYCLES+2.
  - `btn` and `press_pulse` are high after edge DEBOUNCE_CYCLES+3.
- Hold duration: `btn` is non-zero for exactly HOLD_CYCLES cycles.
- Release latency: with `btn` already cleared, `deb` falls DEBOUNCE_CYCLES+2 edges after raw release. `busy` falls 1 edge later.
- Minimum gap between two accepted presses = HOLD_CYCLES + release debounce + 1 cycle.
- Simultaneous press: two raw bits rising in the same cycle debounce on the same edge, so the press is rejected.
- Staggered presses debounced ≥1 cycle apart: the first is accepted and the second is ignored.

## Test plan
Use DEBOUNCE_CYCLES=4 and HOLD_CYCLES=8 throughout.
- Clean press: `btn_raw`=0001, held 40 cycles -> `btn`=0001 and `press_pulse`=1 after edge 7. `btn`=0001 for exactly 8 cycles, then 0. On release, `busy` falls 7 edges after raw falls.
- Bounce: `btn_raw[2]` toggles every cycle for 10 cycles, then holds 1 -> exactly one `press_pulse`, with `btn`=0100 7 edges after the final rising edge. No output during the bounce.
- Multi-press: `btn_raw`=0110 in the same cycle -> `multi_err` pulses after edge 7, `btn` stays 0. Releasing both and then pressing 1000 alone gives an accepted press of 1000.
- Held button: hold 0010 for 100 cycles -> exactly one `press_pulse`. No re-trigger until release debounces, and a second press after release is accepted.
- Early release: press 0001 for 6 cycles after debounce -> `btn` is still held the full 8 cycles.
- Reset mid-HOLD: drive `reset`=0 while `btn`=0100 -> `btn`, `busy` and both strobes read 0 before the next clock edge. With raw still 0100 at release, `btn` is 0100 again 7 edges later.
